// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_pkg
// Purpose  : Shared constants and types for the multi-cycle data-memory responder.
// Revision : 1.0  initial release
// ============================================================================
package dmem_responder_pkg;

    localparam int c_word_w      = 32;
    localparam int c_max_latency = 15;
    localparam int c_cnt_w       = 4;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    typedef logic [c_word_w-1:0] word_t;

endpackage : dmem_responder_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Purpose  : Single-port word store, clocked write and combinational read;
//            contents are never reset.
// Revision : 1.0  initial release
// ============================================================================
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  word_t         wdata,
    output word_t         rdata
);

    word_t r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    assign rdata = r_mem[idx];

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Fixed-latency load/store target that stalls the requester until
//            the access completes and returns read data or an error flag.
// Revision : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3,
    parameter int AW      = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic c_fast = (LATENCY == 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_cnt_w-1:0] r_cnt;

    logic          r_rd;
    logic          r_wr;
    logic          r_err;
    logic [AW-1:0] r_idx;
    word_t         r_wdata;

    logic  r_resp_valid;
    word_t r_resp_rdata;
    logic  r_resp_err;

    logic          w_req;
    logic          w_req_err;
    logic          w_accept;
    logic          w_finish;
    logic          w_sel_rd;
    logic          w_sel_wr;
    logic          w_sel_err;
    logic [AW-1:0] w_sel_idx;
    word_t         w_sel_wdata;
    logic          w_we;
    word_t         w_arr_rdata;

    assign w_req     = req_read | req_write;
    assign w_req_err = (req_addr[1:0] != 2'b00)
                     | (req_addr[31:2] >= 30'(DEPTH))
                     | (req_read & req_write);
    assign w_accept  = (r_state == c_st_idle) & w_req;

    // The commit edge is either the last BUSY edge or, at unit latency, the accept edge itself.
    assign w_finish  = ((r_state == c_st_busy) & (r_cnt == c_cnt_w'(1)))
                     | (w_accept & c_fast);

    // At unit latency the access uses live inputs because nothing is latched yet.
    assign w_sel_rd    = (r_state == c_st_idle) ? req_read           : r_rd;
    assign w_sel_wr    = (r_state == c_st_idle) ? req_write          : r_wr;
    assign w_sel_err   = (r_state == c_st_idle) ? w_req_err          : r_err;
    assign w_sel_idx   = (r_state == c_st_idle) ? req_addr[AW+1:2]   : r_idx;
    assign w_sel_wdata = (r_state == c_st_idle) ? req_wdata          : r_wdata;

    // Reset on the commit edge discards the pending store.
    assign w_we = w_finish & w_sel_wr & ~w_sel_err & ~reset;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clock (clock),
        .we    (w_we),
        .idx   (w_sel_idx),
        .wdata (w_sel_wdata),
        .rdata (w_arr_rdata)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_req) begin
                    w_next_state = c_fast ? c_st_done : c_st_busy;
                end
            end
            c_st_busy: begin
                if (r_cnt == c_cnt_w'(1)) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_done: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_err        <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_resp_valid <= w_finish;
            if (w_accept) begin
                r_rd    <= req_read;
                r_wr    <= req_write;
                r_err   <= w_req_err;
                r_idx   <= req_addr[AW+1:2];
                r_wdata <= req_wdata;
                r_cnt   <= c_cnt_w'(LATENCY - 1);
            end else if (r_state == c_st_busy) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
            if (w_finish) begin
                r_resp_err <= w_sel_err;
                if (w_sel_err) begin
                    r_resp_rdata <= '0;
                end else if (w_sel_rd) begin
                    r_resp_rdata <= w_arr_rdata;
                end
            end
        end
    end

    assign stall      = w_accept | (r_state == c_st_busy);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Scoreboard bench driving two responders (latency 3 and 1) with
//            directed and random load/store traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    typedef struct {
        int          due;
        logic        err;
        logic        known;
        logic [31:0] data;
    } exp_t;

    logic clock = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done [2];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int LAT = (g == 0) ? 3 : 1;

        logic        reset;
        logic        req_read;
        logic        req_write;
        logic [31:0] req_addr;
        logic [31:0] req_wdata;
        logic        stall;
        logic        resp_valid;
        logic [31:0] resp_rdata;
        logic        resp_err;

        exp_t        sb [$];
        logic [31:0] mem_model [int];
        logic [31:0] last_data;
        logic        last_known;

        dmem_responder #(
            .DEPTH   (DEPTH),
            .LATENCY (LAT),
            .AW      (AW)
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .req_read   (req_read),
            .req_write  (req_write),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .stall      (stall),
            .resp_valid (resp_valid),
            .resp_rdata (resp_rdata),
            .resp_err   (resp_err)
        );

        always @(negedge clock) begin
            exp_t e;
            if (resp_valid) begin
                check($sformatf("L%0d resp_expected", LAT), 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check($sformatf("L%0d resp_cycle", LAT), cyc, e.due);
                    check($sformatf("L%0d resp_err", LAT), 32'(resp_err), 32'(e.err));
                    if (e.known) check($sformatf("L%0d resp_rdata", LAT), resp_rdata, e.data);
                end
            end
        end

        // Reference model: apply the access rules directly to a sparse word map.
        task automatic model(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata);
            exp_t e;
            int   idx;
            logic err;
            idx = int'(addr[31:2]);
            err = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH)) || (rd && wr);
            e.due = cyc + LAT;
            e.err = err;
            if (err) begin
                last_data  = 32'h0;
                last_known = 1'b1;
            end else if (rd) begin
                last_known = mem_model.exists(idx);
                last_data  = last_known ? mem_model[idx] : 32'h0;
            end else begin
                mem_model[idx] = wdata;
            end
            e.known = last_known;
            e.data  = last_data;
            sb.push_back(e);
        endtask

        // Entered just after a rising edge with the DUT idle; returns likewise.
        task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata);
            int k;
            req_read  = rd;
            req_write = wr;
            req_addr  = addr;
            req_wdata = wdata;
            model(rd, wr, addr, wdata);
            k = 0;
            forever begin
                @(negedge clock);
                if (!stall || k > 40) break;
                k++;
            end
            check($sformatf("L%0d stall_cycles @%08h", LAT, addr), k, LAT);
            // Garbage on the request lines during the response cycle must be ignored.
            req_read  = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_wdata = $urandom;
            @(posedge clock);
            #1;
            req_read  = 1'b0;
            req_write = 1'b0;
        endtask

        task automatic reset_write(input logic [31:0] addr, input logic [31:0] wdata);
            req_read  = 1'b0;
            req_write = 1'b1;
            req_addr  = addr;
            req_wdata = wdata;
            repeat (LAT - 1) begin
                @(posedge clock);
                #1;
            end
            reset = 1'b1;
            @(posedge clock);
            #1;
            reset     = 1'b0;
            req_write = 1'b0;
            last_data  = 32'h0;
            last_known = 1'b1;
            @(negedge clock);
            check($sformatf("L%0d abort_stall", LAT), 32'(stall), 32'd0);
            check($sformatf("L%0d abort_valid", LAT), 32'(resp_valid), 32'd0);
            check($sformatf("L%0d abort_rdata", LAT), resp_rdata, 32'h0);
            @(posedge clock);
            #1;
        endtask

        initial begin
            logic [31:0] a;
            logic        rd;
            logic        wr;
            reset      = 1'b1;
            req_read   = 1'b0;
            req_write  = 1'b0;
            req_addr   = '0;
            req_wdata  = '0;
            last_data  = 32'h0;
            last_known = 1'b1;
            repeat (3) @(posedge clock);
            #1;
            reset = 1'b0;
            @(negedge clock);
            check($sformatf("L%0d rst_stall", LAT), 32'(stall), 32'd0);
            check($sformatf("L%0d rst_valid", LAT), 32'(resp_valid), 32'd0);
            check($sformatf("L%0d rst_rdata", LAT), resp_rdata, 32'h0);
            check($sformatf("L%0d rst_err", LAT), 32'(resp_err), 32'd0);
            @(posedge clock);
            #1;

            issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
            issue(1'b1, 1'b0, 32'h10, 32'h0);
            issue(1'b0, 1'b1, 32'h20, 32'h0);
            reset_write(32'h20, 32'h12345678);
            issue(1'b1, 1'b0, 32'h20, 32'h0);
            issue(1'b0, 1'b1, 32'h0, 32'h0BAD_F00D);
            issue(1'b0, 1'b1, 32'h4, 32'h1357_9BDF);
            issue(1'b1, 1'b0, 32'h0, 32'h0);
            issue(1'b1, 1'b0, 32'h4, 32'h0);
            issue(1'b1, 1'b0, 32'h13, 32'h0);
            issue(1'b1, 1'b0, 32'h400, 32'h0);
            issue(1'b1, 1'b1, 32'h10, 32'h5555_AAAA);
            issue(1'b1, 1'b0, 32'h10, 32'h0);
            issue(1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
            issue(1'b1, 1'b0, 32'h20, 32'h0);
            issue(1'b0, 1'b1, 32'h24, 32'h7777_8888);

            for (int i = 0; i < 120; i++) begin
                rd = 1'($urandom_range(0, 1));
                wr = ~rd;
                case ($urandom_range(0, 9))
                    7:       a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
                    8:       a = 32'h400 + 32'($urandom_range(0, 4095)) * 4;
                    9: begin
                        a  = 32'($urandom_range(0, 15)) * 4;
                        rd = 1'b1;
                        wr = 1'b1;
                    end
                    6:       a = 32'h3FC;
                    default: a = 32'($urandom_range(0, 15)) * 4;
                endcase
                issue(rd, wr, a, $urandom);
            end

            repeat (LAT + 2) @(posedge clock);
            @(negedge clock);
            check($sformatf("L%0d pending_responses", LAT), sb.size(), 32'd0);
            done[g] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && !(done[0] && done[1]); i++) @(posedge clock);
        check("lanes_finished", 32'(done[0] && done[1]), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
